operand_fetch: RTL and testbench

Pipeline stage directly upstream of the 8×8-bit register file. It takes decoded instructions, drives the register file's two read-address ports, and forwards a writeback value that is landing in the same cycle. A one-bit-per-register scoreboard stalls read-after-write and write-after-write hazards. Operands are registered into a valid/ready output slot for the execute stage.

---
 rtl/operand_fetch_if.sv | 50 +++++
 rtl/operand_fetch.sv | 94 +++++++++
 tb/tb_operand_fetch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Decode/register-file/writeback/execute signals around the operand fetch stage.
// slave is the stage itself; master is everything surrounding it.
interface operand_fetch_if #(
    parameter int AW  = 3,
    parameter int DW  = 8,
    parameter int OPW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [OPW-1:0] in_op;
    logic [AW-1:0]  in_rs1;
    logic [AW-1:0]  in_rs2;
    logic [AW-1:0]  in_rd;
    logic           in_wr;

    logic [AW-1:0]  rf_rs1_addr;
    logic [AW-1:0]  rf_rs2_addr;
    logic [DW-1:0]  rf_rs1_data;
    logic [DW-1:0]  rf_rs2_data;

    logic           wb_we;
    logic [AW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;

    logic           out_valid;
    logic           out_ready;
    logic [OPW-1:0] out_op;
    logic [DW-1:0]  out_op1;
    logic [DW-1:0]  out_op2;
    logic [AW-1:0]  out_rd;
    logic           out_wr;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_wr,
        output rf_rs1_data, rf_rs2_data,
        output wb_we, wb_rd, wb_data,
        output out_ready,
        input  in_ready, rf_rs1_addr, rf_rs2_addr,
        input  out_valid, out_op, out_op1, out_op2, out_rd, out_wr
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_wr,
        input  rf_rs1_data, rf_rs2_data,
        input  wb_we, wb_rd, wb_data,
        input  out_ready,
        output in_ready, rf_rs1_addr, rf_rs2_addr,
        output out_valid, out_op, out_op1, out_op2, out_rd, out_wr
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read with writeback forwarding, a per-register
// pending scoreboard for RAW/WAW stalls, and a one-entry valid/ready output slot.
module operand_fetch #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 8,
    parameter int OPW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    operand_fetch_if.slave bus
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    logic            wb_hit1, wb_hit2, wb_hitd;
    logic            hz1, hz2, hzd, stall, slot_free, issue;
    logic [DW-1:0]   op1_p0, op2_p0;

    logic            vld_p1;
    logic [OPW-1:0]  op_p1;
    logic [DW-1:0]   op1_p1, op2_p1;
    logic [AW-1:0]   rd_p1;
    logic            wr_p1;

    // Writeback value wins over the register file, which only commits on the edge.
    function automatic logic [DW-1:0] fwd_sel(input logic hit, input logic [DW-1:0] wb_val,
                                              input logic [DW-1:0] rf_val);
        return hit ? wb_val : rf_val;
    endfunction

    // ---- stage p0: read, forward, hazard detect ----
    assign bus.rf_rs1_addr = bus.in_rs1;
    assign bus.rf_rs2_addr = bus.in_rs2;

    assign wb_hit1 = bus.wb_we && (bus.wb_rd == bus.in_rs1);
    assign wb_hit2 = bus.wb_we && (bus.wb_rd == bus.in_rs2);
    assign wb_hitd = bus.wb_we && (bus.wb_rd == bus.in_rd);

    assign op1_p0 = fwd_sel(wb_hit1, bus.wb_data, bus.rf_rs1_data);
    assign op2_p0 = fwd_sel(wb_hit2, bus.wb_data, bus.rf_rs2_data);

    // A writeback landing this cycle releases its register without a bubble.
    assign hz1   = pending[bus.in_rs1] && !wb_hit1;
    assign hz2   = pending[bus.in_rs2] && !wb_hit2;
    assign hzd   = bus.in_wr && pending[bus.in_rd] && !wb_hitd;
    assign stall = hz1 || hz2 || hzd;

    assign slot_free    = !vld_p1 || bus.out_ready;
    assign bus.in_ready = !stall && slot_free;
    assign issue        = bus.in_valid && bus.in_ready;

    // Clear first so a same-cycle set of the same index wins.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_we) pending_nxt[bus.wb_rd] = 1'b0;
        if (issue && bus.in_wr) pending_nxt[bus.in_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    // ---- stage p1: output slot ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            op1_p1 <= '0;
            op2_p1 <= '0;
            rd_p1  <= '0;
            wr_p1  <= 1'b0;
        end else if (issue) begin
            vld_p1 <= 1'b1;
            op_p1  <= bus.in_op;
            op1_p1 <= op1_p0;
            op2_p1 <= op2_p0;
            rd_p1  <= bus.in_rd;
            wr_p1  <= bus.in_wr;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_op    = op_p1;
    assign bus.out_op1   = op1_p1;
    assign bus.out_op2   = op2_p1;
    assign bus.out_rd    = rd_p1;
    assign bus.out_wr    = wr_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, scoreboard reference model and a
// separate output monitor, driven by directed scenarios followed by random traffic.
module tb_operand_fetch;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int OPW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if #(.AW(AW), .DW(DW), .OPW(OPW)) ifc ();
    operand_fetch #(.NREG(NREG), .AW(AW), .DW(DW), .OPW(OPW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    // Register file: r[i] = 0x11*(i-1) after reset, so r2=0x11, r3=0x22.
    logic [DW-1:0] rf [NREG];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= DW'(((i + NREG - 1) % NREG) * 17);
        end else if (ifc.wb_we) begin
            rf[ifc.wb_rd] <= ifc.wb_data;
        end
    end
    assign ifc.rf_rs1_data = rf[ifc.rf_rs1_addr];
    assign ifc.rf_rs2_data = rf[ifc.rf_rs2_addr];

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [AW-1:0]  rd;
        logic           wr;
    } slot_t;

    slot_t           sb[$];
    logic [NREG-1:0] mpend, pend_n;
    logic            mvld, vld_n, exp_rdy, fire;
    int              n_chk = 0;
    int              n_pass = 0;
    bit              final_chk = 1'b0;

    // Value a reader sees for register r this cycle.
    function automatic logic [DW-1:0] value_of(input logic [AW-1:0] r);
        return (ifc.wb_we && ifc.wb_rd == r) ? ifc.wb_data : rf[r];
    endfunction

    // A register blocks a reader while an older write is still outstanding.
    function automatic bit busy(input logic [AW-1:0] r);
        return mpend[r] && !(ifc.wb_we && ifc.wb_rd == r);
    endfunction

    // Reference model: state advances on the edge, decisions made once inputs settle.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mpend <= '0;
            mvld  <= 1'b0;
            sb.delete();
        end else begin
            mpend <= pend_n;
            mvld  <= vld_n;
        end
        #2;
        if (!rst) begin
            exp_rdy = !(busy(ifc.in_rs1) || busy(ifc.in_rs2) || (ifc.in_wr && busy(ifc.in_rd)))
                      && (!mvld || ifc.out_ready);
            fire = ifc.in_valid && exp_rdy;
            if (fire)
                sb.push_back('{op: ifc.in_op, a: value_of(ifc.in_rs1), b: value_of(ifc.in_rs2),
                               rd: ifc.in_rd, wr: ifc.in_wr});
            pend_n = mpend;
            if (ifc.wb_we) pend_n[ifc.wb_rd] = 1'b0;
            if (fire && ifc.in_wr) pend_n[ifc.in_rd] = 1'b1;
            vld_n = fire ? 1'b1 : (ifc.out_ready ? 1'b0 : mvld);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor: compares the DUT against the model on every falling edge.
    initial begin
        bit          held;
        logic [31:0] saved, cur;
        slot_t       e;
        held = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk);
            cur = 32'({ifc.out_op, ifc.out_op1, ifc.out_op2, ifc.out_rd, ifc.out_wr});
            if (rst) begin
                chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
                chk("rst_pending", 32'(dut.pending), 32'd0);
                chk("rst_out_data", cur, 32'd0);
                held = 1'b0;
            end else begin
                chk("in_ready", 32'(ifc.in_ready), 32'(exp_rdy));
                chk("out_valid", 32'(ifc.out_valid), 32'(mvld));
                chk("pending", 32'(dut.pending), 32'(mpend));
                if (held) chk("out_hold", cur, saved);
                if (ifc.out_valid && ifc.out_ready) begin
                    chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_slot", cur, 32'(e));
                    end
                end
                held  = ifc.out_valid && !ifc.out_ready;
                saved = cur;
                if (final_chk) chk("sb_drained", 32'(sb.size()), 32'd0);
            end
        end
    end

    task automatic next_cycle(output bit acc);
        @(negedge clk);
        acc = ifc.in_valid && ifc.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [OPW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic wr);
        ifc.in_op  = op;
        ifc.in_rs1 = rs1;
        ifc.in_rs2 = rs2;
        ifc.in_rd  = rd;
        ifc.in_wr  = wr;
        ifc.in_valid = 1'b1;
    endtask

    task automatic send(input logic [OPW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic wr);
        bit acc;
        int w;
        set_in(op, rs1, rs2, rd, wr);
        w = 0;
        do begin
            next_cycle(acc);
            w++;
        end while (!acc && w < 200);
        if (!acc) begin
            $display("FAIL send_timeout: accepted=%0d after %0d cycles, required=1", acc, w);
            $fatal(1);
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic writeback(input logic [AW-1:0] r, input logic [DW-1:0] d);
        ifc.wb_we   = 1'b1;
        ifc.wb_rd   = r;
        ifc.wb_data = d;
    endtask

    initial begin
        bit acc;
        int r;
        ifc.in_valid = 1'b0;
        ifc.in_op = '0; ifc.in_rs1 = '0; ifc.in_rs2 = '0; ifc.in_rd = '0; ifc.in_wr = 1'b0;
        ifc.wb_we = 1'b0; ifc.wb_rd = '0; ifc.wb_data = '0;
        ifc.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Plain read of r2/r3.
        send(4'h1, 3'd2, 3'd3, 3'd0, 1'b0);
        next_cycle(acc);

        // RAW on r5 released by a same-cycle writeback.
        send(4'h2, 3'd0, 3'd0, 3'd5, 1'b1);
        set_in(4'h3, 3'd5, 3'd1, 3'd0, 1'b0);
        repeat (3) next_cycle(acc);
        writeback(3'd5, 8'hA5);
        next_cycle(acc);
        ifc.wb_we = 1'b0;
        ifc.in_valid = 1'b0;
        next_cycle(acc);

        // WAW on r4; the re-set wins over the clearing writeback.
        send(4'h4, 3'd1, 3'd2, 3'd4, 1'b1);
        set_in(4'h5, 3'd2, 3'd3, 3'd4, 1'b1);
        repeat (2) next_cycle(acc);
        writeback(3'd4, 8'h3C);
        next_cycle(acc);
        ifc.in_valid = 1'b0;
        writeback(3'd4, 8'h5A);
        next_cycle(acc);
        ifc.wb_we = 1'b0;

        // Backpressure holds the slot.
        send(4'h6, 3'd3, 3'd4, 3'd0, 1'b0);
        ifc.out_ready = 1'b0;
        set_in(4'h7, 3'd1, 3'd6, 3'd0, 1'b0);
        repeat (4) next_cycle(acc);
        ifc.out_ready = 1'b1;
        next_cycle(acc);
        ifc.in_valid = 1'b0;

        // Six independent instructions back to back.
        for (int i = 0; i < 6; i++) send(OPW'(i + 8), AW'(i), AW'(7 - i), AW'(i), 1'b0);
        next_cycle(acc);

        // Reset with r4/r5 pending and a full slot.
        send(4'h9, 3'd0, 3'd1, 3'd4, 1'b1);
        send(4'hA, 3'd1, 3'd2, 3'd5, 1'b1);
        ifc.out_ready = 1'b0;
        next_cycle(acc);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ifc.out_ready = 1'b1;
        send(4'hB, 3'd5, 3'd5, 3'd0, 1'b0);

        // Random traffic obeying the upstream hold rule.
        acc = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if (acc || !ifc.in_valid) begin
                ifc.in_valid = ($urandom_range(0, 3) != 0);
                ifc.in_op  = OPW'($urandom);
                ifc.in_rs1 = AW'($urandom_range(0, NREG - 1));
                ifc.in_rs2 = AW'($urandom_range(0, NREG - 1));
                ifc.in_rd  = AW'($urandom_range(0, NREG - 1));
                ifc.in_wr  = ($urandom_range(0, 1) == 1);
            end
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, NREG - 1);
            if ((mpend[r] && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0)
                writeback(AW'(r), DW'($urandom));
            else
                ifc.wb_we = 1'b0;
            next_cycle(acc);
        end

        // Drain.
        ifc.in_valid  = 1'b0;
        ifc.wb_we     = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (4) next_cycle(acc);
        final_chk = 1'b1;
        next_cycle(acc);
        final_chk = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
